// File: rtl/sdr_cas_sched.sv
// sdr_cas_sched -- two-port SDRAM command scheduler, one command in flight.
//
// Arbitrates single-beat read/write requests from two client ports
// round-robin, then sequences ACTIVE -> tRCD NOPs -> READ/WRITE -> recovery
// NOPs on the SDRAM command pins. BL=1 with auto-precharge. Read data is
// captured CL clocks after the READ and returned tagged with the requester.
//
// Optional feature macro: SDR_CAS_SCHED_PERF_EN
//   defined   -> perf_rd_cnt / perf_wr_cnt count issued READ / WRITE
//                commands, saturating at 16'hFFFF
//   undefined -> counter ports are tied to zero
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   cfg_sdr_cas[2:0]         CAS latency in clocks (0 behaves as 1)
//   req_valid/req_write[1:0] per-port request and direction (1 = write)
//   req_row/req_col          per-port addresses, port0 in the LSBs
//   req_wdata                per-port write data, port0 in the LSBs
//   req_ready[1:0]           one-cycle accept strobe to the granted port
//   ras_n, cas_n, we_n       SDRAM command (NOP 111, ACT 011, RD 101, WR 100)
//   sdr_addr                 row during ACTIVE, column during READ/WRITE
//   dq_out, dq_oe            write data and its output enable
//   dq_in                    read data from the pins
//   rd_valid/rd_data/rd_id   returned read data pulse with requester id
//   perf_rd_cnt/perf_wr_cnt  command counters (see macro above)
module sdr_cas_sched #(
  parameter int DQ_WIDTH   = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int TRCD       = 2,
  parameter int TRECOV     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              cfg_sdr_cas,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_row,
  input  logic [2*ADDR_WIDTH-1:0] req_col,
  input  logic [2*DQ_WIDTH-1:0]   req_wdata,
  output logic [1:0]              req_ready,
  output logic                    ras_n,
  output logic                    cas_n,
  output logic                    we_n,
  output logic [ADDR_WIDTH-1:0]   sdr_addr,
  output logic [DQ_WIDTH-1:0]     dq_out,
  output logic                    dq_oe,
  input  logic [DQ_WIDTH-1:0]     dq_in,
  output logic                    rd_valid,
  output logic [DQ_WIDTH-1:0]     rd_data,
  output logic                    rd_id,
  output logic [15:0]             perf_rd_cnt,
  output logic [15:0]             perf_wr_cnt
);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;

  typedef enum logic [2:0] {IDLE, ACT, RCD, CMD, REC} state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  last_grant;
  logic                  grant, accept, issue_rd, rd_pending;
  logic [2:0]            cl_eff;
  logic [1:0]            ready_nxt;
  logic [2:0]            cmd_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DQ_WIDTH-1:0]   dq_nxt;
  logic                  oe_nxt;

  logic [ADDR_WIDTH-1:0] row_l, col_l;
  logic [DQ_WIDTH-1:0]   wdata_l;
  logic                  wr_l, id_l;

  // Read-return tracker: bit 0 reaches the front one clock before the
  // dq_in capture cycle; cap_*_p1 marks the capture cycle itself.
  logic [6:0]            sr_vld, sr_id, sr_vld_nxt, sr_id_nxt;
  logic                  cap_vld_p1, cap_id_p1;

  assign cl_eff     = (cfg_sdr_cas == 3'd0) ? 3'd1 : cfg_sdr_cas;
  assign grant      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign accept     = (state == IDLE) && (|req_valid);
  // Any read still owed on dq_in (including its capture cycle) blocks a WRITE,
  // which leaves one idle clock on the bus between read data and write data.
  assign rd_pending = (|sr_vld) | cap_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = 2'b00;
    cmd_nxt   = CMD_NOP;
    addr_nxt  = sdr_addr;
    dq_nxt    = dq_out;
    oe_nxt    = 1'b0;
    issue_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ready_nxt = grant ? 2'b10 : 2'b01;
          state_nxt = ACT;
        end
      end
      ACT: begin
        cmd_nxt  = CMD_ACT;
        addr_nxt = row_l;
        if (TRCD > 1) begin
          state_nxt = RCD;
          cnt_nxt   = 8'(TRCD - 2);
        end else begin
          state_nxt = CMD;
        end
      end
      RCD: begin
        if (cnt == 8'd0) state_nxt = CMD;
        else             cnt_nxt   = cnt - 8'd1;
      end
      CMD: begin
        if (!wr_l) begin
          cmd_nxt   = CMD_RD;
          addr_nxt  = col_l;
          issue_rd  = 1'b1;
          state_nxt = REC;
          cnt_nxt   = 8'(TRECOV - 1);
        end else if (!rd_pending) begin
          cmd_nxt   = CMD_WR;
          addr_nxt  = col_l;
          dq_nxt    = wdata_l;
          oe_nxt    = 1'b1;
          state_nxt = REC;
          cnt_nxt   = 8'(TRECOV - 1);
        end
      end
      REC: begin
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CL is sampled here, at READ issue, by choosing the load slot.
  always_comb begin
    sr_vld_nxt = {1'b0, sr_vld[6:1]};
    sr_id_nxt  = {1'b0, sr_id[6:1]};
    if (issue_rd) begin
      sr_vld_nxt[cl_eff - 3'd1] = 1'b1;
      sr_id_nxt[cl_eff - 3'd1]  = id_l;
    end
  end

  // Accept stage: latch the granted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_l   <= grant ? req_row[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_row[ADDR_WIDTH-1:0];
      col_l   <= grant ? req_col[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_col[ADDR_WIDTH-1:0];
      wdata_l <= grant ? req_wdata[2*DQ_WIDTH-1:DQ_WIDTH] : req_wdata[DQ_WIDTH-1:0];
      wr_l    <= grant ? req_write[1] : req_write[0];
      id_l    <= grant;
    end
  end

  // Pin stage: registered command, address and write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant          <= 1'b1;
      req_ready           <= 2'b00;
      {ras_n, cas_n, we_n} <= CMD_NOP;
      sdr_addr            <= '0;
      dq_out              <= '0;
      dq_oe               <= 1'b0;
    end else begin
      if (accept) last_grant <= grant;
      req_ready           <= ready_nxt;
      {ras_n, cas_n, we_n} <= cmd_nxt;
      sdr_addr            <= addr_nxt;
      dq_out              <= dq_nxt;
      dq_oe               <= oe_nxt;
    end
  end

  // Return stage: latency shift, capture of dq_in, then the rd_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_vld     <= '0;
      sr_id      <= '0;
      cap_vld_p1 <= 1'b0;
      cap_id_p1  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_id      <= 1'b0;
    end else begin
      sr_vld     <= sr_vld_nxt;
      sr_id      <= sr_id_nxt;
      cap_vld_p1 <= sr_vld[0];
      cap_id_p1  <= sr_id[0];
      rd_valid   <= cap_vld_p1;
      if (cap_vld_p1) begin
        rd_data <= dq_in;
        rd_id   <= cap_id_p1;
      end
    end
  end

`ifdef SDR_CAS_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_cnt <= 16'd0;
      perf_wr_cnt <= 16'd0;
    end else begin
      if ((cmd_nxt == CMD_RD) && (perf_rd_cnt != 16'hFFFF)) perf_rd_cnt <= perf_rd_cnt + 16'd1;
      if ((cmd_nxt == CMD_WR) && (perf_wr_cnt != 16'hFFFF)) perf_wr_cnt <= perf_wr_cnt + 16'd1;
    end
  end
`else
  assign perf_rd_cnt = 16'd0;
  assign perf_wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sdr_cas_sched.sv
// Testbench for sdr_cas_sched (DQ 16, ADDR 12, TRCD 2, TRECOV 3).
// Stimulus pushes expected accepts, bus commands and read returns (with the
// absolute cycle they must appear) into queues; a monitor pops and compares
// whenever the DUT presents one. A small SDRAM model drives dq_in.
module tb_sdr_cas_sched;
  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cfg_sdr_cas = 3'd2;
  logic [1:0]  req_valid = '0, req_write = '0, req_ready;
  logic [23:0] req_row = '0, req_col = '0;
  logic [31:0] req_wdata = '0;
  logic        ras_n, cas_n, we_n, dq_oe, rd_valid, rd_id;
  logic [11:0] sdr_addr;
  logic [15:0] dq_out, rd_data, perf_rd_cnt, perf_wr_cnt;
  logic [15:0] dq_in = 16'hFFFF;

  sdr_cas_sched dut (
    .clk(clk), .reset(reset), .cfg_sdr_cas(cfg_sdr_cas),
    .req_valid(req_valid), .req_write(req_write), .req_row(req_row),
    .req_col(req_col), .req_wdata(req_wdata), .req_ready(req_ready),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .sdr_addr(sdr_addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_id(rd_id), .perf_rd_cnt(perf_rd_cnt),
    .perf_wr_cnt(perf_wr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [31:0] cyc; logic [2:0] cmd; logic [11:0] addr; logic oe; logic [15:0] dq;} cmd_e;
  typedef struct packed {logic [31:0] cyc; logic [1:0] rdy;} acc_e;
  typedef struct packed {logic [31:0] cyc; logic id; logic [15:0] d;} rd_e;
  typedef struct packed {logic [31:0] due; logic [15:0] d;} mdl_e;

  cmd_e cmd_q[$];
  acc_e acc_q[$];
  rd_e  rd_q[$];
  mdl_e mdl_q[$];

  int n_chk = 0, n_pass = 0;
  int cl_model = 2;
  int n_rd_iss = 0, n_wr_iss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: unexpected output %h at cycle %0d", name, act, cyc);
  endtask

  function automatic logic [15:0] model_data(input logic [11:0] col);
    return (col == 12'd9) ? 16'hA5A5 : {4'h5, col};
  endfunction

  task automatic push_acc(input int c, input int p);
    acc_e e;
    e.cyc = 32'(c);
    e.rdy = (p == 1) ? 2'b10 : 2'b01;
    acc_q.push_back(e);
  endtask

  task automatic push_cmd(input int c, input logic [2:0] k, input logic [11:0] a,
                          input logic oe, input logic [15:0] d);
    cmd_e e;
    e.cyc = 32'(c); e.cmd = k; e.addr = a; e.oe = oe; e.dq = d;
    cmd_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input int p, input logic [15:0] d);
    rd_e e;
    e.cyc = 32'(c); e.id = (p == 1); e.d = d;
    rd_q.push_back(e);
  endtask

  // Monitor / scoreboard
  acc_e m_acc;
  cmd_e m_cmd;
  rd_e  m_rd;
  always @(negedge clk) begin
    if (req_ready != 2'b00) begin
      if (acc_q.size() == 0) unexpected("accept", {32'(cyc), 30'b0, req_ready});
      else begin
        m_acc = acc_q.pop_front();
        check("accept", {32'(cyc), 30'b0, req_ready}, {m_acc.cyc, 30'b0, m_acc.rdy});
      end
    end
    if (({ras_n, cas_n, we_n} != NOP) || dq_oe) begin
      if (cmd_q.size() == 0)
        unexpected("command", {32'(cyc), ras_n, cas_n, we_n, sdr_addr, dq_oe, dq_out});
      else begin
        m_cmd = cmd_q.pop_front();
        check("command", {32'(cyc), ras_n, cas_n, we_n, sdr_addr, dq_oe, (dq_oe ? dq_out : 16'h0)},
              {m_cmd.cyc, m_cmd.cmd, m_cmd.addr, m_cmd.oe, m_cmd.dq});
      end
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) unexpected("rd_return", {32'(cyc), 15'b0, rd_id, rd_data});
      else begin
        m_rd = rd_q.pop_front();
        check("rd_return", {32'(cyc), 15'b0, rd_id, rd_data}, {m_rd.cyc, 15'b0, m_rd.id, m_rd.d});
      end
    end
  end

  // SDRAM model: return data CL clocks after each READ, garbage otherwise
  mdl_e m_mdl;
  always @(negedge clk) begin
    while (mdl_q.size() != 0 && int'(mdl_q[0].due) < cyc) void'(mdl_q.pop_front());
    dq_in = 16'hFFFF;
    if (mdl_q.size() != 0 && int'(mdl_q[0].due) == cyc) begin
      dq_in = mdl_q[0].d;
      void'(mdl_q.pop_front());
    end
    if ({ras_n, cas_n, we_n} == RD) begin
      m_mdl.due = 32'(cyc + cl_model);
      m_mdl.d   = model_data(sdr_addr);
      mdl_q.push_back(m_mdl);
    end
  end

  // Single request from an idle scheduler; called at a negedge.
  task automatic issue(input int p, input bit wr, input logic [11:0] row,
                       input logic [11:0] col, input logic [15:0] wd);
    int t;
    req_write[p] = wr;
    req_row[p*12 +: 12] = row;
    req_col[p*12 +: 12] = col;
    req_wdata[p*16 +: 16] = wd;
    req_valid[p] = 1'b1;
    t = cyc + 1;
    push_acc(t, p);
    push_cmd(t + 1, ACT, row, 1'b0, 16'h0);
    if (wr) begin
      push_cmd(t + 3, WR, col, 1'b1, wd);
      n_wr_iss++;
    end else begin
      push_cmd(t + 3, RD, col, 1'b0, 16'h0);
      push_rd(t + 4 + cl_model, p, model_data(col));
      n_rd_iss++;
    end
    @(negedge clk);
    req_valid[p] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {ras_n, cas_n, we_n, sdr_addr, dq_out, dq_oe, req_ready, rd_valid, rd_data, rd_id},
          {NOP, 12'h0, 16'h0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0});
    check({name, "_perf"}, {perf_rd_cnt, perf_wr_cnt}, 32'h0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_bus", {ras_n, cas_n, we_n, dq_oe, req_ready}, {NOP, 1'b0, 2'b00});
    end

    // Read CL=2 from port0, then write from port1
    issue(0, 1'b0, 12'd5, 12'd9, 16'h0);
    issue(1, 1'b1, 12'h00A, 12'd3, 16'h1234);

    // Both ports valid continuously: grants 0,1,0,1, one every 7 clocks
    req_write = 2'b11;
    req_row   = {12'h011, 12'h010};
    req_col   = {12'h021, 12'h020};
    req_wdata = {16'h2222, 16'h1111};
    req_valid = 2'b11;
    t = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      push_acc(t + 7*k, k % 2);
      push_cmd(t + 7*k + 1, ACT, (k % 2 == 1) ? 12'h011 : 12'h010, 1'b0, 16'h0);
      push_cmd(t + 7*k + 3, WR, (k % 2 == 1) ? 12'h021 : 12'h020, 1'b1,
               (k % 2 == 1) ? 16'h2222 : 16'h1111);
      n_wr_iss++;
    end
    repeat (22) @(negedge clk);
    req_valid = 2'b00;
    repeat (8) @(negedge clk);

    // Lone port1 read, CAS latency 0 behaves as 1
    cfg_sdr_cas = 3'd0;
    cl_model = 1;
    issue(1, 1'b0, 12'd8, 12'd7, 16'h0);

    // Turnaround: CL=7 read on port0, write on port1 waits for capture + 1
    cfg_sdr_cas = 3'd7;
    cl_model = 7;
    req_write[0] = 1'b0;
    req_row[11:0] = 12'h050;
    req_col[11:0] = 12'h051;
    req_valid = 2'b01;
    t = cyc + 1;
    push_acc(t, 0);
    push_cmd(t + 1, ACT, 12'h050, 1'b0, 16'h0);
    push_cmd(t + 3, RD, 12'h051, 1'b0, 16'h0);
    push_rd(t + 11, 0, model_data(12'h051));
    n_rd_iss++;
    @(negedge clk);
    req_write[1] = 1'b1;
    req_row[23:12] = 12'h060;
    req_col[23:12] = 12'h061;
    req_wdata[31:16] = 16'hBEEF;
    req_valid = 2'b10;
    push_acc(t + 7, 1);
    push_cmd(t + 8, ACT, 12'h060, 1'b0, 16'h0);
    push_cmd(t + 12, WR, 12'h061, 1'b1, 16'hBEEF);
    n_wr_iss++;
    repeat (4) @(negedge clk);
    cfg_sdr_cas = 3'd2;   // must not disturb the in-flight CL=7 read
    cl_model = 2;
    repeat (3) @(negedge clk);
    req_valid = 2'b00;
    repeat (10) @(negedge clk);

    // Reset between READ and its capture: no return, scheduler idle at once
    req_write[0] = 1'b0;
    req_row[11:0] = 12'h044;
    req_col[11:0] = 12'h033;
    req_valid = 2'b01;
    t = cyc + 1;
    push_acc(t, 0);
    push_cmd(t + 1, ACT, 12'h044, 1'b0, 16'h0);
    push_cmd(t + 3, RD, 12'h033, 1'b0, 16'h0);
    n_rd_iss++;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
`ifdef SDR_CAS_SCHED_PERF_EN
    check("perf_counts", {perf_rd_cnt, perf_wr_cnt}, {16'(n_rd_iss), 16'(n_wr_iss)});
`else
    check("perf_counts", {perf_rd_cnt, perf_wr_cnt}, 32'h0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midread_reset");
    reset = 1'b0;
    n_rd_iss = 0;
    n_wr_iss = 0;
    issue(1, 1'b0, 12'h077, 12'h066, 16'h0);

    repeat (10) @(negedge clk);
    check("acc_queue_empty", 64'(acc_q.size()), 64'd0);
    check("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
